// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words into instr_mem and
// holds the CPU in reset until a full frame with a good XOR checksum has arrived.
module imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
   localparam int unsigned IDX_W     = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         bcnt_q, bcnt_d;
   logic [31:0]        n_q, n_d;
   logic [23:0]        wbuf_q, wbuf_d;
   logic [7:0]         acc_q, acc_d;
   logic [IDX_W-1:0]   widx_q, widx_d;
   logic               in_ready_d, mem_we_d, cpu_hold_d, done_d, err_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic [31:0]        mem_wdata_d;
   logic [31:0]        n_full;
   logic               accept;

   assign accept = in_valid & in_ready;
   assign n_full = {in_data, n_q[31:8]};

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      n_d         = n_q;
      wbuf_d      = wbuf_q;
      acc_d       = acc_q;
      widx_d      = widx_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;

      case (state_q)
         S_HDR: begin
            if (accept) begin
               n_d    = n_full;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  if (n_full > 32'(MAX_WORDS)) state_d = S_ERR;
                  else if (n_full == 32'd0)    state_d = S_CSUM;
                  else                         state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               acc_d  = acc_q ^ in_data;
               bcnt_d = bcnt_q + 2'd1;
               case (bcnt_q)
                  2'd0: wbuf_d[7:0]   = in_data;
                  2'd1: wbuf_d[15:8]  = in_data;
                  2'd2: wbuf_d[23:16] = in_data;
                  default: begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = widx_q[ADDR_W-1:0];
                     mem_wdata_d = {in_data, wbuf_q};
                     widx_d      = widx_q + IDX_W'(1);
                     if (32'(widx_q) + 32'd1 == n_q) state_d = S_CSUM;
                  end
               endcase
            end
         end
         S_CSUM: begin
            if (accept) state_d = (in_data == acc_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_HDR;
               bcnt_d  = 2'd0;
               n_d     = 32'd0;
               wbuf_d  = 24'd0;
               acc_d   = 8'd0;
               widx_d  = '0;
            end
         end
         default: state_d = S_HDR;
      endcase

      // Status outputs are a registered image of the next state
      in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
      cpu_hold_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_HDR;
         bcnt_q    <= 2'd0;
         n_q       <= 32'd0;
         wbuf_q    <= 24'd0;
         acc_q     <= 8'd0;
         widx_q    <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         n_q       <= n_d;
         wbuf_q    <= wbuf_d;
         acc_q     <= acc_d;
         widx_q    <= widx_d;
         in_ready  <= in_ready_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         cpu_hold  <= cpu_hold_d;
         done      <= done_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames built from a word-list model, writes
// checked by an independent monitor, status checked at frame boundaries.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        start = 1'b0;
   logic        in_ready, mem_we, cpu_hold, done, err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;

   imem_loader #(.ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] prog_words[$];
   logic [7:0]  frame[$];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor: every mem_we must match the head of the expected queue
   always @(negedge clk) begin
      if (reset === 1'b1 && mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: addr %h data %h at %0t", mem_addr, mem_wdata, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", mem_wdata, e.data);
         end
      end
   end

   // Reference model: frame bytes and expected writes from the word list
   task automatic make_frame(input logic [31:0] n, input bit bad_csum);
      logic [7:0]  acc;
      logic [31:0] w;
      wr_t         e;
      acc = 8'd0;
      frame.delete();
      for (int k = 0; k < 4; k++) frame.push_back(n[8*k +: 8]);
      if (n <= 32'd256) begin
         for (int i = 0; i < int'(n); i++) begin
            w = prog_words[i];
            for (int k = 0; k < 4; k++) begin
               frame.push_back(w[8*k +: 8]);
               acc = acc ^ w[8*k +: 8];
            end
            e.addr = 8'(i);
            e.data = w;
            exp_q.push_back(e);
         end
         frame.push_back(bad_csum ? (acc ^ 8'h01) : acc);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         vectors++;
         miscompares++;
         $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 at %0t", in_ready, $time);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap, input bit poke_start);
      for (int i = 0; i < frame.size(); i++) begin
         if (poke_start) start = (i < frame.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         repeat ($urandom_range(0, max_gap)) @(posedge clk);
         #1 send_byte(frame[i]);
      end
      start = 1'b0;
   endtask

   task automatic finish_check(input bit exp_done, input bit exp_err);
      @(negedge clk);
      @(negedge clk);
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
      chk("in_ready_end", 32'(in_ready), 32'd0);
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("start_done", 32'(done), 32'd0);
      chk("start_err", 32'(err), 32'd0);
      chk("start_hold", 32'(cpu_hold), 32'd1);
      chk("start_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic load_spec_prog();
      prog_words.delete();
      prog_words.push_back(32'h00045B37);
      prog_words.push_back(32'h0012B337);
      prog_words.push_back(32'h000AB3B7);
      prog_words.push_back(32'h00000013);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 check_reset_values("rst");
      reset = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Reference program, good checksum E3
      load_spec_prog();
      make_frame(32'd4, 1'b0);
      chk("spec_csum_byte", 32'(frame[frame.size()-1]), 32'h000000E3);
      send_frame(0, 1'b0);
      finish_check(1'b1, 1'b0);

      // Same program with checksum E2
      do_start();
      make_frame(32'd4, 1'b1);
      send_frame(0, 1'b0);
      finish_check(1'b0, 1'b1);

      // Empty program
      do_start();
      prog_words.delete();
      make_frame(32'd0, 1'b0);
      send_frame(0, 1'b0);
      finish_check(1'b1, 1'b0);

      // Count 257 exceeds capacity
      do_start();
      make_frame(32'd257, 1'b0);
      send_frame(0, 1'b0);
      finish_check(1'b0, 1'b1);

      // From ERR: restart and load with random gaps and ignored start pulses
      do_start();
      load_spec_prog();
      make_frame(32'd4, 1'b0);
      send_frame(5, 1'b1);
      finish_check(1'b1, 1'b0);

      // Reset after the second data word, then reload
      do_start();
      make_frame(32'd4, 1'b0);
      for (int i = 0; i < 12; i++) send_byte(frame[i]);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset_values("midrst");
      chk("midrst_pending", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 make_frame(32'd4, 1'b0);
      send_frame(2, 1'b0);
      finish_check(1'b1, 1'b0);

      // Full capacity
      do_start();
      prog_words.delete();
      for (int i = 0; i < 256; i++) prog_words.push_back($urandom());
      make_frame(32'd256, 1'b0);
      send_frame(0, 1'b0);
      finish_check(1'b1, 1'b0);

      // Random frames
      for (int r = 0; r < 12; r++) begin
         int  n;
         bit  bad;
         do_start();
         n   = $urandom_range(1, 12);
         bad = ($urandom_range(0, 3) == 0);
         prog_words.delete();
         for (int i = 0; i < n; i++) prog_words.push_back($urandom());
         make_frame(32'(n), bad);
         send_frame(3, 1'b1);
         finish_check(!bad, bad);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
